// File: rtl/boxcar_pkg.sv
// Shared constants and types for the averaging-filter / decimator chain.
package boxcar_pkg;

    // Averaging filter defaults: output width grows by LGMEM over its input.
    localparam int unsigned DEF_IW    = 18;
    localparam int unsigned DEF_LGMEM = 4;
    localparam int unsigned DEF_OW    = DEF_IW + DEF_LGMEM;

    // Width of the dropped-sample statistics counter.
    localparam int unsigned DROPCNT_W = 16;

    // One filtered sample as it leaves the averaging filter.
    typedef logic signed [DEF_OW-1:0] sample_t;

endpackage

// File: rtl/boxcar_decimator_if.sv
// Valid/ready output stream carrying decimated samples to the next consumer.
interface boxcar_decimator_if
    import boxcar_pkg::*;
#(
    parameter int unsigned IW = DEF_OW
);
    logic                 o_valid;
    logic                 i_ready;
    logic signed [IW-1:0] o_data;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO: head entry is visible on rd_data_o while not empty.
// A write into a full FIFO is accepted only when a read frees the head slot in the same cycle.
module sync_fifo_fwft #(
    parameter int unsigned DW     = 22,
    parameter int unsigned LGFIFO = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              rd_en_i,
    output logic [DW-1:0]     rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [LGFIFO:0]   level_o
);
    localparam int unsigned DEPTH = 1 << LGFIFO;
    localparam int unsigned PW    = LGFIFO + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          push;
    logic          pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[LGFIFO] != rd_q[LGFIFO]) &&
                     (wr_q[LGFIFO-1:0] == rd_q[LGFIFO-1:0]);
    assign pop     = rd_en_i && !empty_o;
    assign push    = wr_en_i && (!full_o || pop);

    // Pointer advance; extra MSB distinguishes full from empty.
    always_comb begin
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents need no reset since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[LGFIFO-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_q[LGFIFO-1:0]];
    assign level_o   = wr_q - rd_q;

endmodule

// File: rtl/boxcar_decimator.sv
// Keeps one of every D ce-qualified samples and buffers kept samples for a valid/ready consumer.
// Optional build macro BOXCAR_DECIM_DROPCNT_EN enables the saturating dropped-sample counter;
// without it o_drop_count is tied to zero.
module boxcar_decimator
    import boxcar_pkg::*;
#(
    parameter int unsigned IW       = DEF_OW,
    parameter int unsigned LGDEC    = 4,
    parameter int unsigned LGFIFO   = 2,
    parameter logic        FIX_DEC  = 1'b0,
    parameter int unsigned INIT_DEC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [LGDEC-1:0]      i_decim,
    input  logic signed [IW-1:0]  i_sample,
    boxcar_decimator_if.master    out_if,
    output logic [LGFIFO:0]       o_level,
    output logic                  o_overflow,
    output logic [DROPCNT_W-1:0]  o_drop_count
);
    logic [LGDEC-1:0] req_dec;
    logic [LGDEC-1:0] phase_q, phase_d;
    logic [LGDEC-1:0] dec_q, dec_d;
    logic             keep;
    logic             fifo_empty;
    logic             fifo_full;
    logic             drop;
    logic [IW-1:0]    fifo_rd_data;
    logic             overflow_q;

    assign req_dec = FIX_DEC ? LGDEC'(INIT_DEC) : i_decim;

    // Phase counter next state; a new decimation factor is latched only at period wrap.
    always_comb begin
        phase_d = phase_q;
        dec_d   = dec_q;
        if (ce) begin
            if (phase_q == dec_q) begin
                phase_d = '0;
                dec_d   = req_dec;
            end else begin
                phase_d = phase_q + LGDEC'(1);
            end
        end
    end

    // Phase counter and active decimation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            dec_q   <= req_dec;
        end else begin
            phase_q <= phase_d;
            dec_q   <= dec_d;
        end
    end

    assign keep = ce && (phase_q == '0);
    // Full implies non-empty, so a ready consumer always frees a slot this cycle.
    assign drop = keep && fifo_full && !out_if.i_ready;

    sync_fifo_fwft #(
        .DW     (IW),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (keep),
        .wr_data_i (i_sample),
        .rd_en_i   (out_if.i_ready),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .level_o   (o_level)
    );

    assign out_if.o_valid = !fifo_empty;
    assign out_if.o_data  = fifo_rd_data;

    // Sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_overflow = overflow_q;

`ifdef BOXCAR_DECIM_DROPCNT_EN
    logic [DROPCNT_W-1:0] drop_cnt_q;

    // Saturating count of discarded samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROPCNT_W'(1);
        end
    end

    assign o_drop_count = drop_cnt_q;
`else
    assign o_drop_count = '0;
`endif

endmodule
